// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell plus a carry
// flop, producing the result LSB-first over WIDTH cycles, then carry-out and overflow.
module serial_add_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic [1:0]       fsm_state
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             carry;
   logic             bit_s;
   logic             carry_nxt;
   logic             last_bit;
   logic             load;

   // Full-adder cell shared by every bit position.
   always_comb begin
      bit_s     = a_sr[0] ^ b_sr[0] ^ carry;
      carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
      last_bit  = (cnt == CW'(WIDTH - 1));
      load      = (state == IDLE) && start;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   assign fsm_state = state;

   // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr     <= '0;
         b_sr     <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else if (load) begin
         a_sr  <= a;
         b_sr  <= op_sub ? ~b : b;
         carry <= op_sub;
         cnt   <= '0;
         sum   <= '0;
      end else if (state == SHIFT) begin
         a_sr  <= a_sr >> 1;
         b_sr  <= b_sr >> 1;
         carry <= carry_nxt;
         sum   <= {bit_s, sum[WIDTH-1:1]};
         cnt   <= cnt + CW'(1);
         // On the MSB, carry still holds the carry into the MSB.
         if (last_bit) begin
            cout     <= carry_nxt;
            overflow <= carry ^ carry_nxt;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_nxt == SHIFT);
         done <= (state_nxt == DONE);
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: directed corners, protocol cases and random ops on a
// WIDTH=8 instance, plus an exhaustive sweep on a WIDTH=4 instance.
module tb_serial_add_sub;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   logic       start8, op8, busy8, done8, cout8, ovf8;
   logic [7:0] a8, b8, sum8;
   logic [1:0] fsm8;
   logic       start4, op4, busy4, done4, cout4, ovf4;
   logic [3:0] a4, b4, sum4;
   logic [1:0] fsm4;

   serial_add_sub #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .op_sub(op8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8),
      .fsm_state(fsm8)
   );

   serial_add_sub #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .op_sub(op4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4),
      .fsm_state(fsm4)
   );

   typedef struct {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
      int         done_at;
      string      tag;
   } exp_t;

   exp_t q8[$];
   exp_t q4[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
   endtask

   // Reference: integer arithmetic on unsigned and signed interpretations.
   function automatic exp_t model(input int w, input logic op, input int av, input int bv);
      exp_t e;
      int   m, sa, sb, r, u;
      m      = 1 << w;
      u      = op ? (av - bv) : (av + bv);
      e.sum  = 8'(((u % m) + m) % m);
      e.cout = op ? (av >= bv) : (av + bv >= m);
      sa     = (av >= m / 2) ? av - m : av;
      sb     = (bv >= m / 2) ? bv - m : bv;
      r      = op ? (sa - sb) : (sa + sb);
      e.ovf  = (r < -(m / 2)) || (r >= m / 2);
      e.done_at = 0;
      e.tag  = "";
      return e;
   endfunction

   always @(negedge clk) begin : mon8
      exp_t e;
      if (done8) begin
         if (q8.size() == 0) begin
            check("done8_unexpected", done8, 0);
         end else begin
            e = q8.pop_front();
            check({e.tag, "_latency"}, edge_cnt, e.done_at);
            check({e.tag, "_sum"}, sum8, e.sum);
            check({e.tag, "_cout"}, cout8, e.cout);
            check({e.tag, "_ovf"}, ovf8, e.ovf);
         end
      end else if (q8.size() > 0 && edge_cnt > q8[0].done_at) begin
         e = q8.pop_front();
         check({e.tag, "_done_timeout"}, done8, 1);
      end
   end

   always @(negedge clk) begin : mon4
      exp_t e;
      if (done4) begin
         if (q4.size() == 0) begin
            check("done4_unexpected", done4, 0);
         end else begin
            e = q4.pop_front();
            check({e.tag, "_latency"}, edge_cnt, e.done_at);
            check({e.tag, "_sum"}, sum4, e.sum[3:0]);
            check({e.tag, "_cout"}, cout4, e.cout);
            check({e.tag, "_ovf"}, ovf4, e.ovf);
         end
      end else if (q4.size() > 0 && edge_cnt > q4[0].done_at) begin
         e = q4.pop_front();
         check({e.tag, "_done_timeout"}, done4, 1);
      end
   end

   // Called at a negedge; returns at the negedge where the next start can be issued.
   task automatic issue8(input logic op, input logic [7:0] av, input logic [7:0] bv,
                         input string tag, input bit chk_busy);
      exp_t e;
      start8 = 1'b1; op8 = op; a8 = av; b8 = bv;
      e = model(8, op, av, bv);
      e.done_at = edge_cnt + 1 + 8;
      e.tag = tag;
      q8.push_back(e);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start8 = 1'b0;
         if (chk_busy) check($sformatf("%s_busy_c%0d", tag, k), busy8, (k <= 8));
      end
   endtask

   task automatic issue4(input logic op, input logic [3:0] av, input logic [3:0] bv,
                         input string tag);
      exp_t e;
      start4 = 1'b1; op4 = op; a4 = av; b4 = bv;
      e = model(4, op, av, bv);
      e.done_at = edge_cnt + 1 + 4;
      e.tag = tag;
      q4.push_back(e);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         start4 = 1'b0;
      end
   endtask

   initial begin : main
      exp_t e;
      rst = 1'b1;
      start8 = 0; op8 = 0; a8 = 0; b8 = 0;
      start4 = 0; op4 = 0; a4 = 0; b4 = 0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy8, 0);
      check("rst_done", done8, 0);
      check("rst_sum", sum8, 0);
      check("rst_cout", cout8, 0);
      check("rst_ovf", ovf8, 0);
      check("rst_state", fsm8, 0);
      rst = 1'b0;
      @(negedge clk);

      issue8(0, 8'h35, 8'h4A, "add_35_4a", 1'b1);
      issue8(0, 8'hFF, 8'h01, "add_ff_01", 1'b0);
      issue8(0, 8'h7F, 8'h01, "add_7f_01", 1'b0);
      issue8(0, 8'h80, 8'h80, "add_80_80", 1'b0);
      issue8(1, 8'h05, 8'h07, "sub_05_07", 1'b0);
      issue8(1, 8'h80, 8'h01, "sub_80_01", 1'b0);
      issue8(1, 8'h10, 8'h10, "sub_10_10", 1'b0);

      // A start pulse while busy must be dropped.
      start8 = 1'b1; op8 = 1'b0; a8 = 8'h01; b8 = 8'h02;
      e = model(8, 1'b0, 8'h01, 8'h02);
      e.done_at = edge_cnt + 9;
      e.tag = "busy_ignore";
      q8.push_back(e);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start8 = (k == 3);
         if (k == 3) begin a8 = 8'h10; b8 = 8'h20; end
      end

      // start held high: second op accepted at cycle 10, done at cycle 19.
      start8 = 1'b1; op8 = 1'b0; a8 = 8'h80; b8 = 8'h80;
      e = model(8, 1'b0, 8'h80, 8'h80);
      e.tag = "b2b_first";
      e.done_at = edge_cnt + 9;
      q8.push_back(e);
      e.tag = "b2b_second";
      e.done_at = edge_cnt + 19;
      q8.push_back(e);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 11) start8 = 1'b0;
      end

      // Reset in the middle of an operation; no done pulse may follow.
      start8 = 1'b1; op8 = 1'b0; a8 = 8'h35; b8 = 8'h4A;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      check("midop_busy_before", busy8, 1);
      rst = 1'b1;
      #1;
      check("midrst_busy", busy8, 0);
      check("midrst_done", done8, 0);
      check("midrst_sum", sum8, 0);
      check("midrst_cout", cout8, 0);
      check("midrst_ovf", ovf8, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      issue8(0, 8'h01, 8'h01, "after_rst", 1'b0);

      for (int i = 0; i < 40; i++) begin
         issue8(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), $sformatf("rand%0d", i), 1'b0);
      end

      for (int op = 0; op < 2; op++)
         for (int av = 0; av < 16; av++)
            for (int bv = 0; bv < 16; bv++)
               issue4(1'(op), 4'(av), 4'(bv), $sformatf("w4_%0d_%0h_%0h", op, av, bv));

      repeat (5) @(negedge clk);
      check("q8_drained", q8.size(), 0);
      check("q4_drained", q4.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Bit-serial two's-complement adder/subtractor built around a single XOR-based full-adder cell and a carry flip-flop. It accepts two WIDTH-bit operands on a start pulse and produces the sum or difference LSB-first over WIDTH clock cycles. It then reports carry-out and signed overflow. It is the sequential counterpart of the combinational full-adder datapath: the same sum/carry equations are reused one bit per cycle in place of WIDTH parallel cells.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op_sub  input  1  0 = a+b, 1 = a−b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when the result is valid
- sum  output  WIDTH  result register
- cout  output  1  final carry (for subtract: 1 = no borrow, i.e. a ≥ b unsigned)
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

## Operation
- One clock domain. Reset is asynchronous and active-high.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, with start=1 at a clock edge:
  - Latch a into the A shift register.
  - Latch b into the B shift register; store ~b when op_sub=1.
  - Set carry = op_sub.
  - Clear the bit counter and sum; go to SHIFT.
- IDLE, with start=0: stay in IDLE.
- SHIFT, one bit per cycle:
  - s = A[0] ^ B[0] ^ carry.
  - carry ← (A[0]&B[0]) | (A[0]&carry) | (B[0]&carry).
  - Shift sum right, inserting s at the MSB.
  - Shift A and B right.
  - Increment the counter.
  - On the bit at index WIDTH−1, capture the carry-in before the update so overflow can be formed.
  - After the WIDTH-th bit, go to DONE.
- DONE: assert done for one cycle. cout and overflow are registered. Go to IDLE unconditionally.
- start is ignored in SHIFT and DONE. It is not queued.
- sum, cout and overflow hold their values from DONE until the next accepted start.
- The counter is ⌈log2(WIDTH+1)⌉ bits wide. All arithmetic is modulo 2^WIDTH.
- Reset, asynchronous at any time including mid-operation:
  - state = IDLE; busy, done, sum, cout and overflow = 0.
  - The counter, shift registers and carry are cleared.
  - An aborted operation produces no done pulse.

## Timing
- Cycle 0 is the edge at which start is sampled in IDLE.
- busy is high for cycles 1 through WIDTH (the SHIFT state), and low in IDLE and DONE.
- done is high for exactly cycle WIDTH+1. sum, cout and overflow are valid in that cycle.
- Total latency from start to done is WIDTH+1 cycles. For WIDTH=8, done is asserted 9 cycles after start.
- The earliest next accepted start is sampled at cycle WIDTH+2, since IDLE is re-entered after DONE. Sustained throughput is one operation per WIDTH+2 cycles.
- During SHIFT, sum holds partial results and is not valid.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then add (WIDTH=8): op_sub=0, a=0x35, b=0x4A -> done at cycle 9, sum=0x7F, cout=0, overflow=0. busy is high for exactly cycles 1–8.
- Carry and overflow corners (WIDTH=8):
  - 0xFF+0x01 -> sum=0x00, cout=1, ovf=0.
  - 0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
  - 0x80+0x80 -> sum=0x00, cout=1, ovf=1.
- Subtract (WIDTH=8):
  - 0x05−0x07 -> sum=0xFE, cout=0, ovf=0.
  - 0x80−0x01 -> sum=0x7F, cout=1, ovf=1.
  - 0x10−0x10 -> sum=0x00, cout=1, ovf=0.
- Start while busy: start with 0x01+0x02, then pulse start with 0x10+0x20 at cycle 3.
  - Required: the second request is ignored; done at cycle 9 with sum=0x03.
  - Back-to-back start held high: next op accepted at cycle 10, done at cycle 19.
- Reset mid-operation: start 0x35+0x4A, assert rst between edges at cycle 4.
  - Required: busy, done, sum, cout and ovf go to 0 immediately with no done pulse.
  - After rst deasserts, 0x01+0x01 gives sum=0x02 at its own cycle 9.
- Exhaustive, WIDTH=4: all 16×16×2 combinations of a, b and op_sub, checked against a behavioral model for sum, cout and overflow.
  - done must be asserted exactly 5 cycles after each start.
  - Exactly one done pulse per operation.
